axi_rd_rr_arbiter: RTL and testbench



---
 rtl/axi_rd_rr_arbiter.sv | 174 +++++++++++++++++
 tb/tb_axi_rd_rr_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin N:1 arbiter sharing one AXI read slave (AR/R) between NUM_REQ requesters.
// Define AXI_RD_ARB_WDOG_EN to add a DATA-state stall watchdog that aborts a hung burst.
module axi_rd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 4096
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic [NUM_REQ*ADDR_W-1:0]   REQ_ARADDR,
  input  logic [NUM_REQ*8-1:0]        REQ_ARLEN,
  input  logic [NUM_REQ-1:0]          REQ_ARVALID,
  output logic [NUM_REQ-1:0]          REQ_ARREADY,
  output logic [DATA_W-1:0]           REQ_RDATA,
  output logic                        REQ_RLAST,
  output logic [NUM_REQ-1:0]          REQ_RVALID,
  input  logic [NUM_REQ-1:0]          REQ_RREADY,
  output logic [ID_W-1:0]             M_AXI_ARID,
  output logic [ADDR_W-1:0]           M_AXI_ARADDR,
  output logic [7:0]                  M_AXI_ARLEN,
  output logic [2:0]                  M_AXI_ARSIZE,
  output logic [1:0]                  M_AXI_ARBURST,
  output logic                        M_AXI_ARVALID,
  input  logic                        M_AXI_ARREADY,
  input  logic [ID_W-1:0]             M_AXI_RID,
  input  logic [DATA_W-1:0]           M_AXI_RDATA,
  input  logic                        M_AXI_RLAST,
  input  logic                        M_AXI_RVALID,
  output logic                        M_AXI_RREADY,
  output logic                        ARB_ERR,
  output logic [1:0]                  dbg_state
);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // valid and ready are both high; valid, once raised, holds until that edge.

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   grant, rr_ptr, pick, grant_inc;
  logic [ID_W-1:0]    grant_id;
  logic [7:0]         len_q, beat_cnt, pick_len;
  logic               any_req, r_hs, err_set, wdog_fire;
  int                 idx;

  assign dbg_state     = state;
  assign REQ_RDATA     = M_AXI_RDATA;
  assign REQ_RLAST     = M_AXI_RLAST;
  assign M_AXI_ARSIZE  = 3'($clog2(DATA_W/8));
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARID    = grant_id;

  // Search order starts at rr_ptr and wraps, so the last-served requester comes last.
  always_comb begin
    any_req  = 1'b0;
    pick     = rr_ptr;
    pick_len = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && REQ_ARVALID[idx]) begin
        any_req = 1'b1;
        pick    = IDX_W'(idx);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == IDX_W'(i)) pick_len = REQ_ARLEN[i*8 +: 8];
    end
  end

  always_comb begin
    M_AXI_ARADDR = '0;
    M_AXI_ARLEN  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        M_AXI_ARADDR = REQ_ARADDR[i*ADDR_W +: ADDR_W];
        M_AXI_ARLEN  = REQ_ARLEN[i*8 +: 8];
      end
    end
  end

  always_comb begin
    grant_id              = '0;
    grant_id[IDX_W-1:0]   = grant;
  end

  assign grant_inc = (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
  assign r_hs      = (state == DATA) && M_AXI_RVALID && M_AXI_RREADY;

  always_comb begin
    state_nxt     = state;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    REQ_ARREADY   = '0;
    REQ_RVALID    = '0;
    case (state)
      IDLE: if (any_req) state_nxt = ADDR;
      ADDR: begin
        M_AXI_ARVALID      = 1'b1;
        REQ_ARREADY[grant] = M_AXI_ARREADY;
        if (M_AXI_ARREADY) state_nxt = DATA;
      end
      DATA: begin
        REQ_RVALID[grant] = M_AXI_RVALID;
        M_AXI_RREADY      = REQ_RREADY[grant];
        if ((M_AXI_RVALID && REQ_RREADY[grant] && M_AXI_RLAST) || wdog_fire)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Protocol violations never change the burst flow; they only raise the sticky flag.
  assign err_set = (r_hs &&  M_AXI_RLAST && (beat_cnt != len_q)) ||
                   (r_hs && !M_AXI_RLAST && (beat_cnt == len_q)) ||
                   (r_hs && (M_AXI_RID != grant_id))             ||
                   (M_AXI_RVALID && (state != DATA))             ||
                   wdog_fire;

`ifdef AXI_RD_ARB_WDOG_EN
  logic [15:0] stall_cnt;

  assign wdog_fire = (state == DATA) && !r_hs && (stall_cnt == 16'(TIMEOUT-1));

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      stall_cnt <= '0;
    end else if ((state == DATA) && !r_hs && !wdog_fire) begin
      stall_cnt <= stall_cnt + 16'd1;
    end else begin
      stall_cnt <= '0;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN && wdog_fire)
      $display("axi_rd_rr_arbiter: read watchdog expired, grant=%0d beat_cnt=%0d", grant, beat_cnt);
  end
`else
  assign wdog_fire = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      ARB_ERR  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set) ARB_ERR <= 1'b1;
      if ((state == IDLE) && any_req) begin
        grant    <= pick;
        len_q    <= pick_len;
        beat_cnt <= '0;
      end else if (r_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      if ((r_hs && M_AXI_RLAST) || wdog_fire) rr_ptr <= grant_inc;
    end
  end

endmodule

// File: tb/tb_axi_rd_rr_arbiter.sv
// Bench for axi_rd_rr_arbiter: bus-level requester/slave models driven each cycle and a
// round-robin/burst reference model; define AXI_RD_ARB_WDOG_EN to include the watchdog step.
module tb_axi_rd_rr_arbiter;

  localparam int NR = 4;
  localparam int IDW = 2;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NR*AW-1:0]  REQ_ARADDR = '0;
  logic [NR*8-1:0]   REQ_ARLEN = '0;
  logic [NR-1:0]     REQ_ARVALID = '0;
  logic [NR-1:0]     REQ_ARREADY;
  logic [DW-1:0]     REQ_RDATA;
  logic              REQ_RLAST;
  logic [NR-1:0]     REQ_RVALID;
  logic [NR-1:0]     REQ_RREADY = '0;
  logic [IDW-1:0]    M_AXI_ARID;
  logic [AW-1:0]     M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY = 1'b0;
  logic [IDW-1:0]    M_AXI_RID = '0;
  logic [DW-1:0]     M_AXI_RDATA = '0;
  logic              M_AXI_RLAST = 1'b0;
  logic              M_AXI_RVALID = 1'b0;
  logic              M_AXI_RREADY;
  logic              ARB_ERR;
  logic [1:0]        dbg_state;

  axi_rd_rr_arbiter #(
    .NUM_REQ(NR), .ID_W(IDW), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn),
    .REQ_ARADDR(REQ_ARADDR), .REQ_ARLEN(REQ_ARLEN), .REQ_ARVALID(REQ_ARVALID),
    .REQ_ARREADY(REQ_ARREADY), .REQ_RDATA(REQ_RDATA), .REQ_RLAST(REQ_RLAST),
    .REQ_RVALID(REQ_RVALID), .REQ_RREADY(REQ_RREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .ARB_ERR(ARB_ERR), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench time limit reached");
  end

  // ---------------- bench state ----------------
  int checks = 0;
  int errors = 0;

  // requester side
  logic [NR-1:0]  rq_want = '0;
  logic [AW-1:0]  rq_addr [NR];
  logic [7:0]     rq_len  [NR];
  bit             continuous = 0;
  int             rready_mode = 0;
  int             stall_left = 0;
  bit             stall_arm = 0;
  int             r2_beats = 0;
  int             rx_beats [NR];

  // slave side
  bit             s_active = 0;
  logic [AW-1:0]  s_addr = '0;
  logic [7:0]     s_len = '0;
  logic [IDW-1:0] s_id = '0;
  int             s_beat = 0;
  bit             s_rv_hold = 0;
  int             early_beat = -1;
  bit             no_data = 0;
  bit             arready_rand = 0;
  bit             gaps = 0;
  int             wd_stall = 0;

  // reference model
  int             m_phase = 0;      // 0 bus free, 1 address offered, 2 data owned
  int             m_owner = 0;
  int             last_served = NR-1;
  bit             exp_err = 0;
  int             bursts_done = 0;
  logic [DW-1:0]  exp_q [$];
  int             obs_ids [$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'h0123_4567};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_winner(input logic [NR-1:0] want, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (want[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic reset_model();
    m_phase = 0; last_served = NR-1; exp_err = 0; exp_q.delete();
    s_active = 0; s_rv_hold = 0; s_beat = 0; wd_stall = 0;
    rq_want = '0; stall_left = 0; stall_arm = 0; continuous = 0;
  endtask

  // ---------------- driver + monitor, one cycle ----------------
  task automatic step();
    int w;
    bit hs;
    logic [DW-1:0] e;
    @(negedge clk);
    M_AXI_ARREADY = arready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    if (s_active && !no_data) begin
      if (!s_rv_hold) M_AXI_RVALID = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      M_AXI_RDATA = mem_word(s_addr + AW'(s_beat * 16));
      M_AXI_RLAST = (s_beat == ((early_beat >= 0) ? early_beat : int'(s_len)));
      M_AXI_RID   = s_id;
    end else begin
      M_AXI_RVALID = 1'b0;
      M_AXI_RLAST  = 1'b0;
      M_AXI_RDATA  = {$urandom, $urandom, $urandom, $urandom};
      M_AXI_RID    = '0;
    end
    REQ_ARVALID = rq_want;
    for (int i = 0; i < NR; i++) begin
      REQ_ARADDR[i*AW +: AW] = rq_addr[i];
      REQ_ARLEN[i*8 +: 8]    = rq_len[i];
      REQ_RREADY[i] = (rready_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
    if (stall_left > 0) REQ_RREADY[2] = 1'b0;
    #1;
    check("rdata_follow", REQ_RDATA, M_AXI_RDATA);
    check("rlast_follow", REQ_RLAST, M_AXI_RLAST);
    check("arb_err", ARB_ERR, exp_err);
    case (m_phase)
      0: begin
        check("idle_arvalid", M_AXI_ARVALID, 0);
        check("idle_arready", REQ_ARREADY, 0);
        check("idle_rvalid", REQ_RVALID, 0);
        if (|rq_want) begin
          w = rr_winner(rq_want, last_served);
          m_owner = w;
          m_phase = 1;
          for (int k = 0; k <= int'(rq_len[w]); k++) exp_q.push_back(mem_word(rq_addr[w] + AW'(k * 16)));
        end
      end
      1: begin
        check("addr_arvalid", M_AXI_ARVALID, 1);
        check("addr_arid", M_AXI_ARID, m_owner);
        check("addr_araddr", M_AXI_ARADDR, rq_addr[m_owner]);
        check("addr_arlen", M_AXI_ARLEN, rq_len[m_owner]);
        check("addr_arsize", M_AXI_ARSIZE, 4);
        check("addr_arburst", M_AXI_ARBURST, 1);
        check("addr_arready", REQ_ARREADY, M_AXI_ARREADY ? (1 << m_owner) : 0);
        check("addr_rvalid", REQ_RVALID, 0);
        if (M_AXI_ARREADY) begin
          obs_ids.push_back(int'(M_AXI_ARID));
          s_active = 1; s_addr = M_AXI_ARADDR; s_len = M_AXI_ARLEN; s_id = M_AXI_ARID;
          s_beat = 0; s_rv_hold = 0; wd_stall = 0;
          if (continuous) rq_addr[m_owner] = $urandom & ~32'hF;
          else rq_want[m_owner] = 1'b0;
          m_phase = 2;
        end
      end
      default: begin
        check("data_rvalid", REQ_RVALID, M_AXI_RVALID ? (1 << m_owner) : 0);
        check("data_rready", M_AXI_RREADY, REQ_RREADY[m_owner]);
        check("data_arvalid", M_AXI_ARVALID, 0);
        if (stall_left > 0 && m_owner == 2) check("stall_rready", M_AXI_RREADY, 0);
        hs = M_AXI_RVALID && REQ_RREADY[m_owner];
        if (hs) begin
          s_rv_hold = 0; wd_stall = 0;
          rx_beats[m_owner]++;
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rdata", REQ_RDATA, e);
          end
          if (m_owner == 2) begin
            r2_beats++;
            if (stall_arm && r2_beats == 2) begin stall_left = 6; stall_arm = 0; end
          end
          s_beat++;
          if (M_AXI_RLAST) begin
            if (exp_q.size() != 0) exp_err = 1;
            exp_q.delete();
            s_active = 0; last_served = m_owner; m_phase = 0; bursts_done++;
          end else if (exp_q.size() == 0) begin
            exp_err = 1;
          end
        end else begin
          s_rv_hold = M_AXI_RVALID;
`ifdef AXI_RD_ARB_WDOG_EN
          wd_stall++;
          if (wd_stall == TO) begin
            exp_err = 1; exp_q.delete(); s_active = 0; no_data = 0;
            last_served = m_owner; m_phase = 0; bursts_done++;
          end
`endif
        end
      end
    endcase
    if (stall_left > 0) stall_left--;
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while (((|rq_want) || m_phase != 0) && cyc < budget) begin
      step();
      cyc++;
    end
    check("drain_done", cyc < budget, 1);
  endtask

  task automatic run_bursts(input int n, input int budget);
    int cyc, start;
    cyc = 0;
    start = bursts_done;
    while (bursts_done < start + n && cyc < budget) begin
      step();
      cyc++;
    end
    check("bursts_done", bursts_done >= start + n, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int exp_order [6];
    int base;
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NR; i++) begin rq_addr[i] = '0; rq_len[i] = '0; rx_beats[i] = 0; end

    // reset values
    M_AXI_RDATA = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #2;
    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_arready", REQ_ARREADY, 0);
    check("rst_rvalid", REQ_RVALID, 0);
    check("rst_rready", M_AXI_RREADY, 0);
    check("rst_err", ARB_ERR, 0);
    check("rst_rdata", REQ_RDATA, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    step();

    // single requester 0, four beats
    rq_addr[0] = 32'h1000; rq_len[0] = 8'd3; rq_want = 4'b0001;
    drain(100);
    check("s1_beats", rx_beats[0], 4);
    check("s1_id", obs_ids[obs_ids.size()-1], 0);
    step();
    check("s1_err", ARB_ERR, 0);

    // bring the pointer round to requester 0 first
    rq_addr[3] = 32'h3000; rq_len[3] = 8'd1; rq_want = 4'b1000;
    drain(100);

    // all four requesting continuously, single-beat bursts
    obs_ids.delete();
    for (int i = 0; i < NR; i++) begin rx_beats[i] = 0; rq_len[i] = 8'd0; rq_addr[i] = 32'h4000 + 32'(i * 32'h100); end
    continuous = 1; rq_want = 4'b1111;
    run_bursts(8, 200);
    continuous = 0; rq_want = '0;
    drain(50);
    for (int k = 0; k < 6; k++) check("rr_order", obs_ids[k], exp_order[k]);
    for (int i = 0; i < NR; i++) check("rr_beats_each", rx_beats[i], 2);

    // randomized contention with gaps and backpressure
    gaps = 1; arready_rand = 1; rready_mode = 1;
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < NR; i++) begin
        rq_addr[i] = $urandom & ~32'hF;
        rq_len[i]  = 8'($urandom_range(0, 7));
      end
      rq_want = 4'($urandom_range(1, 15));
      drain(600);
    end
    gaps = 0; arready_rand = 0; rready_mode = 0;

    // requester 2 holds RREADY low mid-burst
    rx_beats[2] = 0; r2_beats = 0; stall_arm = 1;
    rq_addr[2] = 32'h0002_0000; rq_len[2] = 8'd7; rq_want = 4'b0100;
    drain(100);
    check("stall_beats", rx_beats[2], 8);

    // slave ends an ARLEN=3 burst after two beats
    rq_addr[1] = 32'h0001_0000; rq_len[1] = 8'd3; rq_want = 4'b0010;
    early_beat = 1;
    drain(100);
    early_beat = -1;
    step();
    check("early_last_err", ARB_ERR, 1);
    rq_addr[3] = 32'h0003_0000; rq_len[3] = 8'd2; rq_want = 4'b1000;
    drain(100);
    check("after_err_id", obs_ids[obs_ids.size()-1], 3);

    // asynchronous reset in the middle of requester 1's data phase
    rq_addr[1] = 32'h0005_0000; rq_len[1] = 8'd7; rq_want = 4'b0010;
    base = 0;
    while (m_phase != 2 && base < 20) begin step(); base++; end
    step(); step();
    check("pre_rst_phase", m_phase, 2);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_arvalid", M_AXI_ARVALID, 0);
    check("mid_rst_rvalid", REQ_RVALID, 0);
    check("mid_rst_rready", M_AXI_RREADY, 0);
    check("mid_rst_arready", REQ_ARREADY, 0);
    check("mid_rst_err", ARB_ERR, 0);
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; REQ_ARVALID = '0;
    reset_model();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    obs_ids.delete();
    rq_addr[1] = 32'h0006_0000; rq_len[1] = 8'd1;
    rq_addr[3] = 32'h0007_0000; rq_len[3] = 8'd1;
    rq_want = 4'b1010;
    drain(100);
    check("post_rst_first", obs_ids[0], 1);
    check("post_rst_second", obs_ids[1], 3);

`ifdef AXI_RD_ARB_WDOG_EN
    // slave accepts the address and never returns data
    obs_ids.delete();
    rq_addr[0] = 32'h0008_0000; rq_len[0] = 8'd1;
    rq_addr[1] = 32'h0009_0000; rq_len[1] = 8'd1;
    no_data = 1; rq_want = 4'b0011;
    drain(200);
    check("wdog_err", ARB_ERR, 1);
    check("wdog_first", obs_ids[0], 0);
    check("wdog_next", obs_ids[1], 1);
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
